register_read_arbiter: RTL and testbench
========================================

REGISTER_READ_ARBITER -- requirements
Module: register_read_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the shared 16-to-1 multiplexer data path.
REQ-002 The block SHALL have parameter SEL_WIDTH, default 4, giving the width of the multiplexer select (16 sources).
REQ-003 The block SHALL use a single clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  3  per-requester read request; bit i belongs to requester i.
- addr0, addr1, addr2  input  SEL_WIDTH each  source index wanted by requester 0/1/2.
- grant  output  3  one-hot acceptance pulse for the requester being served.
- mux_sel  output  SEL_WIDTH  registered select driven to the shared 16-to-1 multiplexer.
- mux_data  input  DATA_WIDTH  multiplexer output, combinational from mux_sel.
- rdata  output  DATA_WIDTH  captured read data.
- rvalid  output  1  one-cycle pulse marking rdata valid.
- rid  output  2  requester index (0-2) owning rdata; valid only while rvalid=1.
- busy  output  1  high while a read is in flight (READ state).

Function
REQ-004 The block SHALL implement a two-state FSM with states IDLE and READ.
REQ-005 In IDLE with req != 0, the block SHALL select winner w by round-robin: the first set req bit found scanning ptr, ptr+1, ptr+2 modulo 3.
REQ-006 grant[w] SHALL be asserted combinationally in that same IDLE cycle, and all other grant bits SHALL be 0.
REQ-007 grant SHALL be 0 in READ, in IDLE with req=0, and whenever reset=1.
REQ-008 On the clock edge ending a granting IDLE cycle, the block SHALL register mux_sel<=addr_w, record w, set ptr<=(w+1) mod 3, and move to READ.
REQ-009 In READ, busy SHALL be 1 and mux_sel SHALL hold stable.
REQ-010 On the clock edge ending READ, the block SHALL capture rdata<=mux_data, set rid<=w, pulse rvalid=1 for exactly one cycle, and return to IDLE.
REQ-011 Latency SHALL be 2 cycles from the grant cycle to the rvalid cycle.
REQ-012 A new grant MAY occur in the same cycle that rvalid is high, giving a sustained throughput of one read per 2 cycles.
REQ-013 mux_sel and rdata SHALL hold their last values when idle; rdata SHALL change only together with an rvalid pulse.
REQ-014 req sampled in READ SHALL be ignored, with no queuing.
REQ-015 A request deasserted before it is granted SHALL be dropped with no side effects.
REQ-016 A requester holding req high SHALL be granted within 3 grant opportunities (starvation-free).
REQ-017 When a single requester is active, it SHALL win every IDLE cycle regardless of ptr.
REQ-018 When requesters are equal, the same source address SHALL be served independently to each, with no merging.

Reset
REQ-019 While reset=1, asynchronously: state=IDLE, ptr=0, mux_sel=0, rdata=0, rid=0, rvalid=0, busy=0, grant=0.
REQ-020 Reset asserted during READ SHALL abort the transaction, and no rvalid SHALL follow.
REQ-021 The first grant after reset release SHALL be evaluated on the first rising clk edge with reset=0.

Verification
REQ-022 The bench SHALL model the shared multiplexer as mux_data = 32'hA000_0000 + mux_sel, and SHALL cover:
- Single read: req=3'b010, addr1=4'd14 -> grant=3'b010 in cycle N; mux_sel=4'hE, busy=1 in N+1; rdata=32'hA000_000E, rid=1, rvalid=1 in N+2 only.
- All requesting: req=3'b111 held, addr0=1, addr1=2, addr2=3 -> grant order 0,1,2,0 in cycles 0,2,4,6; rdata 32'hA000_0001, ..._0002, ..._0003, ..._0001.
- Pointer wrap: after serving requester 2, req=3'b101 -> requester 0 granted next, then requester 2.
- Ignored in READ: req pulsed 3'b100 for one cycle only during READ -> no grant[2], no extra rvalid.
- Reset mid-operation: reset asserted in READ cycle -> outputs 0 immediately, no rvalid; after release, req=3'b011 -> requester 0 granted first (ptr=0).
- Back-to-back: req[0] held, addr0 changing 0 -> 15 -> rvalid every 2nd cycle with rdata 32'hA000_0000, then 32'hA000_000F.

Source files
------------

// File: rtl/register_read_arbiter.sv
// Round-robin read arbiter: three requesters share one registered 16-to-1 mux select.
// Each grant is followed by one READ cycle, then rdata/rid/rvalid are presented for one cycle.
module register_read_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SEL_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            req,
   input  logic [SEL_WIDTH-1:0]  addr0,
   input  logic [SEL_WIDTH-1:0]  addr1,
   input  logic [SEL_WIDTH-1:0]  addr2,
   output logic [2:0]            grant,
   output logic [SEL_WIDTH-1:0]  mux_sel,
   input  logic [DATA_WIDTH-1:0] mux_data,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic [1:0]            rid,
   output logic                  busy
);

   typedef enum logic [0:0] {StIdle, StRead} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [1:0]            r_ptr;
   logic [1:0]            r_win;
   logic [SEL_WIDTH-1:0]  r_mux_sel;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rid;
   logic                  r_rvalid;

   logic [1:0]            w_win;
   logic [1:0]            w_ptr_next;
   logic                  w_grant_vld;
   logic [SEL_WIDTH-1:0]  w_addr;

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // First set request bit scanning ptr, ptr+1, ptr+2 (mod 3).
   always_comb begin
      logic [1:0] w_o1;
      logic [1:0] w_o2;
      w_o1 = inc3(r_ptr);
      w_o2 = inc3(w_o1);
      if (req[r_ptr])     w_win = r_ptr;
      else if (req[w_o1]) w_win = w_o1;
      else                w_win = w_o2;
   end

   assign w_grant_vld = !reset && (r_state == StIdle) && (req != 3'b000);
   assign w_ptr_next  = inc3(w_win);

   always_comb begin
      unique case (w_win)
         2'd0:    w_addr = addr0;
         2'd1:    w_addr = addr1;
         default: w_addr = addr2;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_grant_vld) w_state_next = StRead;
         default: w_state_next = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      grant = 3'b000;
      busy  = (r_state == StRead);
      if (w_grant_vld) grant = 3'b001 << w_win;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr     <= 2'd0;
         r_win     <= 2'd0;
         r_mux_sel <= '0;
         r_rdata   <= '0;
         r_rid     <= 2'd0;
         r_rvalid  <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         if (w_grant_vld) begin
            r_mux_sel <= w_addr;
            r_win     <= w_win;
            r_ptr     <= w_ptr_next;
         end
         if (r_state == StRead) begin
            r_rdata  <= mux_data;
            r_rid    <= r_win;
            r_rvalid <= 1'b1;
         end
      end
   end

   assign mux_sel = r_mux_sel;
   assign rdata   = r_rdata;
   assign rid     = r_rid;
   assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_register_read_arbiter.sv
// Directed bench for register_read_arbiter: a per-cycle vector table plus hand sequences
// for mid-cycle asynchronous reset and grant-to-rvalid latency.
module tb_register_read_arbiter;

   localparam logic [31:0] B = 32'hA000_0000;

   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [3:0]  addr0, addr1, addr2;
   logic [2:0]  grant;
   logic [3:0]  mux_sel;
   logic [31:0] mux_data;
   logic [31:0] rdata;
   logic        rvalid;
   logic [1:0]  rid;
   logic        busy;

   int total = 0;
   int bad   = 0;

   register_read_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .addr0    (addr0),
      .addr1    (addr1),
      .addr2    (addr2),
      .grant    (grant),
      .mux_sel  (mux_sel),
      .mux_data (mux_data),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .rid      (rid),
      .busy     (busy)
   );

   assign mux_data = B + {28'd0, mux_sel};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [3:0]  a0, a1, a2;
      logic [2:0]  grant;
      logic        busy;
      logic [3:0]  sel;
      logic        rvalid;
      logic [31:0] rdata;
      logic [1:0]  rid;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rs, input logic [2:0] rq, input logic [3:0] a0,
                      input logic [3:0] a1, input logic [3:0] a2, input logic [2:0] g,
                      input logic bz, input logic [3:0] sl, input logic rv,
                      input logic [31:0] rd, input logic [1:0] ri);
      vec_t v;
      v.rst = rs; v.req = rq; v.a0 = a0; v.a1 = a1; v.a2 = a2;
      v.grant = g; v.busy = bz; v.sel = sl; v.rvalid = rv; v.rdata = rd; v.rid = ri;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      int lat;
      reset = 1'b1; req = 3'b000; addr0 = 4'd0; addr1 = 4'd0; addr2 = 4'd0;

      //  rst req     a0     a1     a2     grant  busy sel    rv   rdata   rid
      add(1, 3'b000, 4'd0,  4'd0,  4'd0,  3'b000, 0, 4'd0,  0, 32'd0,   2'd0);
      // single read
      add(0, 3'b010, 4'd0,  4'd14, 4'd0,  3'b010, 0, 4'd0,  0, 32'd0,   2'd0);
      add(0, 3'b000, 4'd0,  4'd14, 4'd0,  3'b000, 1, 4'd14, 0, 32'd0,   2'd0);
      add(0, 3'b000, 4'd0,  4'd14, 4'd0,  3'b000, 0, 4'd14, 1, B + 14,  2'd1);
      add(0, 3'b000, 4'd0,  4'd14, 4'd0,  3'b000, 0, 4'd14, 0, B + 14,  2'd0);
      // reset in idle, then all three requesting
      add(1, 3'b000, 4'd0,  4'd0,  4'd0,  3'b000, 0, 4'd0,  0, 32'd0,   2'd0);
      add(0, 3'b111, 4'd1,  4'd2,  4'd3,  3'b001, 0, 4'd0,  0, 32'd0,   2'd0);
      add(0, 3'b111, 4'd1,  4'd2,  4'd3,  3'b000, 1, 4'd1,  0, 32'd0,   2'd0);
      add(0, 3'b111, 4'd1,  4'd2,  4'd3,  3'b010, 0, 4'd1,  1, B + 1,   2'd0);
      add(0, 3'b111, 4'd1,  4'd2,  4'd3,  3'b000, 1, 4'd2,  0, B + 1,   2'd0);
      add(0, 3'b111, 4'd1,  4'd2,  4'd3,  3'b100, 0, 4'd2,  1, B + 2,   2'd1);
      add(0, 3'b111, 4'd1,  4'd2,  4'd3,  3'b000, 1, 4'd3,  0, B + 2,   2'd0);
      add(0, 3'b111, 4'd1,  4'd2,  4'd3,  3'b001, 0, 4'd3,  1, B + 3,   2'd2);
      add(0, 3'b000, 4'd1,  4'd2,  4'd3,  3'b000, 1, 4'd1,  0, B + 3,   2'd0);
      add(0, 3'b000, 4'd1,  4'd2,  4'd3,  3'b000, 0, 4'd1,  1, B + 1,   2'd0);
      // pointer wrap: serve 2, then 0 before 2
      add(0, 3'b100, 4'd1,  4'd2,  4'd3,  3'b100, 0, 4'd1,  0, B + 1,   2'd0);
      add(0, 3'b000, 4'd1,  4'd2,  4'd3,  3'b000, 1, 4'd3,  0, B + 1,   2'd0);
      add(0, 3'b101, 4'd1,  4'd2,  4'd3,  3'b001, 0, 4'd3,  1, B + 3,   2'd2);
      add(0, 3'b101, 4'd1,  4'd2,  4'd3,  3'b000, 1, 4'd1,  0, B + 3,   2'd0);
      add(0, 3'b101, 4'd1,  4'd2,  4'd3,  3'b100, 0, 4'd1,  1, B + 1,   2'd0);
      add(0, 3'b000, 4'd1,  4'd2,  4'd3,  3'b000, 1, 4'd3,  0, B + 1,   2'd0);
      add(0, 3'b000, 4'd1,  4'd2,  4'd3,  3'b000, 0, 4'd3,  1, B + 3,   2'd2);
      // request pulsed during READ is ignored
      add(0, 3'b001, 4'd5,  4'd2,  4'd3,  3'b001, 0, 4'd3,  0, B + 3,   2'd0);
      add(0, 3'b100, 4'd5,  4'd2,  4'd3,  3'b000, 1, 4'd5,  0, B + 3,   2'd0);
      add(0, 3'b000, 4'd5,  4'd2,  4'd3,  3'b000, 0, 4'd5,  1, B + 5,   2'd0);
      add(0, 3'b000, 4'd5,  4'd2,  4'd3,  3'b000, 0, 4'd5,  0, B + 5,   2'd0);
      // reset during READ aborts; pointer back to 0
      add(0, 3'b010, 4'd5,  4'd7,  4'd3,  3'b010, 0, 4'd5,  0, B + 5,   2'd0);
      add(1, 3'b000, 4'd5,  4'd7,  4'd3,  3'b000, 0, 4'd0,  0, 32'd0,   2'd0);
      add(0, 3'b000, 4'd5,  4'd7,  4'd3,  3'b000, 0, 4'd0,  0, 32'd0,   2'd0);
      add(0, 3'b011, 4'd2,  4'd7,  4'd3,  3'b001, 0, 4'd0,  0, 32'd0,   2'd0);
      add(0, 3'b000, 4'd2,  4'd7,  4'd3,  3'b000, 1, 4'd2,  0, 32'd0,   2'd0);
      add(0, 3'b000, 4'd2,  4'd7,  4'd3,  3'b000, 0, 4'd2,  1, B + 2,   2'd0);
      // back-to-back on requester 0, addr 0 then 15
      add(0, 3'b001, 4'd0,  4'd7,  4'd3,  3'b001, 0, 4'd2,  0, B + 2,   2'd0);
      add(0, 3'b001, 4'd15, 4'd7,  4'd3,  3'b000, 1, 4'd0,  0, B + 2,   2'd0);
      add(0, 3'b001, 4'd15, 4'd7,  4'd3,  3'b001, 0, 4'd0,  1, B + 0,   2'd0);
      add(0, 3'b000, 4'd15, 4'd7,  4'd3,  3'b000, 1, 4'd15, 0, B + 0,   2'd0);
      add(0, 3'b000, 4'd15, 4'd7,  4'd3,  3'b000, 0, 4'd15, 1, B + 15,  2'd0);
      // same address for two requesters served separately
      add(0, 3'b011, 4'd9,  4'd9,  4'd3,  3'b010, 0, 4'd15, 0, B + 15,  2'd0);
      add(0, 3'b011, 4'd9,  4'd9,  4'd3,  3'b000, 1, 4'd9,  0, B + 15,  2'd0);
      add(0, 3'b011, 4'd9,  4'd9,  4'd3,  3'b001, 0, 4'd9,  1, B + 9,   2'd1);
      add(0, 3'b000, 4'd9,  4'd9,  4'd3,  3'b000, 1, 4'd9,  0, B + 9,   2'd0);
      add(0, 3'b000, 4'd9,  4'd9,  4'd3,  3'b000, 0, 4'd9,  1, B + 9,   2'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         reset = vecs[i].rst; req = vecs[i].req;
         addr0 = vecs[i].a0; addr1 = vecs[i].a1; addr2 = vecs[i].a2;
         @(negedge clk);
         chk($sformatf("v%0d grant", i),   32'(grant),   32'(vecs[i].grant));
         chk($sformatf("v%0d busy", i),    32'(busy),    32'(vecs[i].busy));
         chk($sformatf("v%0d mux_sel", i), 32'(mux_sel), 32'(vecs[i].sel));
         chk($sformatf("v%0d rvalid", i),  32'(rvalid),  32'(vecs[i].rvalid));
         chk($sformatf("v%0d rdata", i),   rdata,        vecs[i].rdata);
         if (vecs[i].rvalid) chk($sformatf("v%0d rid", i), 32'(rid), 32'(vecs[i].rid));
      end

      // Asynchronous reset asserted mid-cycle while in READ
      @(posedge clk); #1;
      req = 3'b100; addr2 = 4'd4;
      @(negedge clk);
      chk("async grant", 32'(grant), 32'(3'b100));
      @(posedge clk); #1;
      req = 3'b000;
      #2 chk("async busy before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("async busy",    32'(busy),    32'd0);
      chk("async mux_sel", 32'(mux_sel), 32'd0);
      chk("async rdata",   rdata,        32'd0);
      chk("async rvalid",  32'(rvalid),  32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("no rvalid after abort c%0d", c), 32'(rvalid), 32'd0);
         @(posedge clk); #1;
      end

      // Grant-to-rvalid latency with a bounded wait
      req = 3'b001; addr0 = 4'd6;
      @(negedge clk);
      chk("lat grant", 32'(grant), 32'(3'b001));
      lat = 0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         req = 3'b000;
         @(negedge clk);
         if (rvalid) begin
            lat = c;
            break;
         end
      end
      chk("lat cycles", 32'(lat), 32'd2);
      chk("lat rdata",  rdata,    B + 6);
      chk("lat rid",    32'(rid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
